// File: rtl/dict_pkg.sv
// Shared types and default sizes for the word-dictionary search controller.
package dict_pkg;

  localparam int DICT_ENTRIES    = 8;
  localparam int DICT_KEY_WIDTH  = 8;
  localparam int DICT_KEY_LENGTH = 4;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_FORGET = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/dict_key_compare.sv
// Combinational full-name equality between a stored dictionary entry and a search key.
module dict_key_compare #(
  parameter int KEY_WIDTH  = 8,
  parameter int KEY_LENGTH = 4
) (
  input  logic [KEY_WIDTH-1:0] i_a [KEY_LENGTH-1:0],
  input  logic [KEY_WIDTH-1:0] i_b [KEY_LENGTH-1:0],
  output logic                 o_match
);

  always_comb begin
    o_match = 1'b1;
    for (int c = 0; c < KEY_LENGTH; c++) begin
      if (i_a[c] != i_b[c]) o_match = 1'b0;
    end
  end

endmodule

// File: rtl/dict_search_ctrl.sv
// Dictionary controller: insert/lookup/clear over valid/ready, newest-to-oldest scan.
// Optional forget operation (op 11) is built only when DICT_FORGET_EN is defined.
module dict_search_ctrl
  import dict_pkg::*;
#(
  parameter  int ENTRIES    = DICT_ENTRIES,
  parameter  int KEY_WIDTH  = DICT_KEY_WIDTH,
  parameter  int KEY_LENGTH = DICT_KEY_LENGTH,
  localparam int INDEX_BITS = $clog2(ENTRIES),
  localparam int COUNT_BITS = $clog2(ENTRIES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_op,
  input  logic [KEY_WIDTH-1:0]  i_key [KEY_LENGTH-1:0],
  output logic                  o_done,
  output logic                  o_found,
  output logic [INDEX_BITS-1:0] o_index,
  output logic                  o_error,
  output logic [COUNT_BITS-1:0] o_count
);

  localparam logic [COUNT_BITS-1:0] CAP = COUNT_BITS'(ENTRIES);

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
  logic [INDEX_BITS-1:0]   index_q, index_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic                    found_q, found_d;
  logic                    error_q, error_d;
  logic                    write_en;
  logic                    accept;
  logic                    match;
  op_t                     req_op;
  logic [KEY_WIDTH-1:0]    key_q [KEY_LENGTH-1:0];
  logic [KEY_WIDTH-1:0]    dict_q [ENTRIES-1:0][KEY_LENGTH-1:0];
  logic [KEY_WIDTH-1:0]    entry [KEY_LENGTH-1:0];
`ifdef DICT_FORGET_EN
  logic                    forget_q;
`endif

  assign req_op = op_t'(i_op);
  assign accept = i_valid && (state_q == IDLE);

  always_comb begin
    for (int c = 0; c < KEY_LENGTH; c++) entry[c] = dict_q[ptr_q][c];
  end

  dict_key_compare #(
    .KEY_WIDTH (KEY_WIDTH),
    .KEY_LENGTH(KEY_LENGTH)
  ) u_compare (
    .i_a    (entry),
    .i_b    (key_q),
    .o_match(match)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    found_d  = found_q;
    index_d  = index_q;
    error_d  = error_q;
    write_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          found_d = 1'b0;
          index_d = '0;
          error_d = 1'b0;
          state_d = DONE;
          case (req_op)
            OP_INSERT: begin
              if (count_q < CAP) begin
                write_en = 1'b1;
                index_d  = count_q[INDEX_BITS-1:0];
                count_d  = count_q + 1'b1;
              end else begin
                error_d = 1'b1;
              end
            end
            OP_CLEAR: count_d = '0;
`ifdef DICT_FORGET_EN
            OP_LOOKUP, OP_FORGET: begin
`else
            OP_LOOKUP: begin
`endif
              if (count_q != '0) begin
                ptr_d   = INDEX_BITS'(count_q - 1'b1);
                state_d = SCAN;
              end
            end
`ifndef DICT_FORGET_EN
            OP_FORGET: error_d = 1'b1;
`endif
          endcase
        end
      end
      SCAN: begin
        if (match) begin
          found_d = 1'b1;
          index_d = ptr_q;
          state_d = DONE;
`ifdef DICT_FORGET_EN
          // Forgetting a word also drops every definition made after it.
          if (forget_q) count_d = COUNT_BITS'(ptr_q);
`endif
        end else if (ptr_q == '0) begin
          index_d = '0;
          state_d = DONE;
`ifdef DICT_FORGET_EN
          if (forget_q) error_d = 1'b1;
`endif
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      found_q <= 1'b0;
      index_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      found_q <= found_d;
      index_q <= index_d;
      error_q <= error_d;
    end
  end

  // Key latch and name table are plain storage; reset deliberately leaves them alone.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int c = 0; c < KEY_LENGTH; c++) key_q[c] <= i_key[c];
`ifdef DICT_FORGET_EN
      forget_q <= (req_op == OP_FORGET);
`endif
    end
    if (write_en && !i_reset) begin
      for (int c = 0; c < KEY_LENGTH; c++) dict_q[count_q[INDEX_BITS-1:0]][c] <= i_key[c];
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_done  = (state_q == DONE);
  assign o_found = found_q;
  assign o_index = index_q;
  assign o_error = error_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_dict_search_ctrl.sv
// Directed self-checking bench for dict_search_ctrl; honours DICT_FORGET_EN for the op-11 scenario.
module tb_dict_search_ctrl;

  localparam int KL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [1:0] op;
  logic [7:0] key [KL-1:0];
  logic       done;
  logic       found;
  logic [2:0] index;
  logic       error;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  dict_search_ctrl dut (
    .i_clk  (clk),
    .i_reset(rst),
    .i_valid(valid),
    .o_ready(ready),
    .i_op   (op),
    .i_key  (key),
    .o_done (done),
    .o_found(found),
    .o_index(index),
    .o_error(error),
    .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic setKey(input string s);
    for (int c = 0; c < KL; c++) key[c] = (c < s.len()) ? s[c] : 8'h20;
  endtask

  // Issues one request and returns the cycle offset of o_done after the accepting edge.
  task automatic request(input logic [1:0] rop, input string name, output int lat);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_before_%s: got %b want 1", name, ready); end
    op = rop;
    setKey(name);
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    setKey("ZZZZ");
    op = 2'b00;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = k; break; end
    end
    if (lat == 0) begin checks++; errors++; $display("[TB] FAIL timeout_%s: got no o_done want pulse", name); end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; op = 2'b00; setKey("    ");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (found !== 1'b0) begin errors++; $display("[TB] FAIL reset_found: got %b want 0", found); end
    checks++; if (index !== 3'd0) begin errors++; $display("[TB] FAIL reset_index: got %0d want 0", index); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b want 0", error); end
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    rst = 1'b0;
  endtask

  task automatic test_insert;
    string names [3] = '{"DUP ", "SWAP", "DROP"};
    int lat;
    for (int i = 0; i < 3; i++) begin
      request(2'b01, names[i], lat);
      checks++; if (lat != 1) begin errors++; $display("[TB] FAIL ins_lat_%0d: got %0d want 1", i, lat); end
      checks++; if (index !== 3'(i)) begin errors++; $display("[TB] FAIL ins_index_%0d: got %0d want %0d", i, index, i); end
      checks++; if (error !== 1'b0 || found !== 1'b0) begin errors++; $display("[TB] FAIL ins_flags_%0d: got err=%b found=%b want 0 0", i, error, found); end
    end
    checks++; if (count !== 4'd3) begin errors++; $display("[TB] FAIL ins_count: got %0d want 3", count); end
  endtask

  task automatic test_lookup;
    int lat;
    request(2'b00, "DUP ", lat);
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL lk_dup_lat: got %0d want 4", lat); end
    checks++; if (found !== 1'b1 || index !== 3'd0) begin errors++; $display("[TB] FAIL lk_dup: got found=%b idx=%0d want 1 0", found, index); end
    request(2'b00, "DROP", lat);
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL lk_drop_lat: got %0d want 2", lat); end
    checks++; if (found !== 1'b1 || index !== 3'd2) begin errors++; $display("[TB] FAIL lk_drop: got found=%b idx=%0d want 1 2", found, index); end
    repeat (3) @(negedge clk);
    checks++; if (found !== 1'b1 || index !== 3'd2 || done !== 1'b0) begin errors++; $display("[TB] FAIL lk_hold: got found=%b idx=%0d done=%b want 1 2 0", found, index, done); end
  endtask

  task automatic test_forget;
    int lat;
`ifdef DICT_FORGET_EN
    request(2'b11, "SWAP", lat);
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL fg_lat: got %0d want 3", lat); end
    checks++; if (found !== 1'b1 || index !== 3'd1 || error !== 1'b0) begin errors++; $display("[TB] FAIL fg_hit: got found=%b idx=%0d err=%b want 1 1 0", found, index, error); end
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL fg_count: got %0d want 1", count); end
    request(2'b11, "OVER", lat);
    checks++; if (lat != 2 || error !== 1'b1 || found !== 1'b0) begin errors++; $display("[TB] FAIL fg_miss: got lat=%0d err=%b found=%b want 2 1 0", lat, error, found); end
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL fg_miss_count: got %0d want 1", count); end
    request(2'b01, "SWAP", lat);
    request(2'b01, "DROP", lat);
    checks++; if (count !== 4'd3 || index !== 3'd2) begin errors++; $display("[TB] FAIL fg_restore: got count=%0d idx=%0d want 3 2", count, index); end
`else
    request(2'b11, "SWAP", lat);
    checks++; if (lat != 1) begin errors++; $display("[TB] FAIL fg_off_lat: got %0d want 1", lat); end
    checks++; if (error !== 1'b1 || found !== 1'b0) begin errors++; $display("[TB] FAIL fg_off_flags: got err=%b found=%b want 1 0", error, found); end
    checks++; if (count !== 4'd3) begin errors++; $display("[TB] FAIL fg_off_count: got %0d want 3", count); end
`endif
  endtask

  task automatic test_shadow;
    int lat;
    request(2'b01, "DUP ", lat);
    checks++; if (index !== 3'd3) begin errors++; $display("[TB] FAIL sh_ins_index: got %0d want 3", index); end
    request(2'b00, "DUP ", lat);
    checks++; if (lat != 2 || found !== 1'b1 || index !== 3'd3) begin errors++; $display("[TB] FAIL sh_lookup: got lat=%0d found=%b idx=%0d want 2 1 3", lat, found, index); end
    request(2'b00, "OVER", lat);
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL sh_miss_lat: got %0d want 5", lat); end
    checks++; if (found !== 1'b0 || index !== 3'd0 || error !== 1'b0) begin errors++; $display("[TB] FAIL sh_miss: got found=%b idx=%0d err=%b want 0 0 0", found, index, error); end
  endtask

  task automatic test_full;
    string names [4] = '{"W4", "W5", "W6", "W7"};
    int lat;
    for (int i = 0; i < 4; i++) begin
      request(2'b01, names[i], lat);
      checks++; if (index !== 3'(i + 4)) begin errors++; $display("[TB] FAIL fl_index_%0d: got %0d want %0d", i, index, i + 4); end
    end
    request(2'b01, "W8", lat);
    checks++; if (lat != 1 || error !== 1'b1) begin errors++; $display("[TB] FAIL fl_overflow: got lat=%0d err=%b want 1 1", lat, error); end
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL fl_count: got %0d want 8", count); end
    request(2'b10, "", lat);
    checks++; if (lat != 1 || count !== 4'd0) begin errors++; $display("[TB] FAIL clr: got lat=%0d count=%0d want 1 0", lat, count); end
    checks++; if (error !== 1'b0 || found !== 1'b0) begin errors++; $display("[TB] FAIL clr_flags: got err=%b found=%b want 0 0", error, found); end
    request(2'b00, "DUP ", lat);
    checks++; if (lat != 1 || found !== 1'b0) begin errors++; $display("[TB] FAIL empty_lk: got lat=%0d found=%b want 1 0", lat, found); end
  endtask

  task automatic test_back_to_back;
    int lat;
    request(2'b01, "A", lat);
    checks++; if (count !== 4'd1 || index !== 3'd0) begin errors++; $display("[TB] FAIL b2b_first: got count=%0d idx=%0d want 1 0", count, index); end
    request(2'b01, "B", lat);
    checks++; if (lat != 1 || count !== 4'd2 || index !== 3'd1) begin errors++; $display("[TB] FAIL b2b_second: got lat=%0d count=%0d idx=%0d want 1 2 1", lat, count, index); end
  endtask

  task automatic test_reset_mid_scan;
    string names [6] = '{"F2", "F3", "F4", "F5", "F6", "F7"};
    int  lat;
    bit  seen = 0;
    for (int i = 0; i < 6; i++) request(2'b01, names[i], lat);
    checks++; if (count !== 4'd8) begin errors++; $display("[TB] FAIL rs_fill: got %0d want 8", count); end
    @(negedge clk);
    op = 2'b00; setKey("OVER"); valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 1'b1 || count !== 4'd0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rs_after: got ready=%b count=%0d done=%b want 1 0 0", ready, count, done); end
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("[TB] FAIL rs_no_done: got pulse want none"); end
  endtask

  initial begin
    test_reset();
    test_insert();
    test_lookup();
    test_forget();
    test_shadow();
    test_full();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
